// File: rtl/dnn_pkg.sv
// Shared definitions for the post-DNN keyword decision path.
package dnn_pkg;

  localparam int unsigned DEF_SCORE_W   = 11;
  localparam int unsigned DEF_NUM_CLASS = 8;
  localparam int unsigned FILLER_CLASS  = 0;

  // Width of a class index; never narrower than one bit.
  function automatic int unsigned cls_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DETECT  = 2'd1,
    HOLD_ST = 2'd2
  } decide_state_e;

endpackage

// File: rtl/dnn_frame_argmax.sv
// Per-frame argmax over the serial class scores.
// DNN_DECIDE_SCORE_GATE_EN: frames whose max is below MIN_SCORE commit as the
// filler class, and the frame max is exported on best_score.
module dnn_frame_argmax
  import dnn_pkg::*;
#(
  parameter int unsigned NUM_CLASS = DEF_NUM_CLASS,
  parameter int unsigned SCORE_W   = DEF_SCORE_W,
`ifdef DNN_DECIDE_SCORE_GATE_EN
  parameter int          MIN_SCORE = 0,
`endif
  localparam int unsigned CLS_W    = cls_w(NUM_CLASS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [SCORE_W-1:0] score_in,
  input  logic                      score_dv,
`ifdef DNN_DECIDE_SCORE_GATE_EN
  output logic signed [SCORE_W-1:0] best_score,
`endif
  output logic [CLS_W-1:0]          frame_class,
  output logic                      frame_valid
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASS - 1);
`ifdef DNN_DECIDE_SCORE_GATE_EN
  localparam logic signed [SCORE_W-1:0] MIN_S = SCORE_W'(MIN_SCORE);
  logic signed [SCORE_W-1:0] best_q, best_d;
`endif

  logic [CLS_W-1:0]          idx_q, idx_d;
  logic [CLS_W-1:0]          arg_q, arg_d;
  logic [CLS_W-1:0]          cls_q, cls_d;
  logic signed [SCORE_W-1:0] max_q, max_d;
  logic                      fv_q, fv_d;

  logic                      take;
  logic signed [SCORE_W-1:0] cand_max;
  logic [CLS_W-1:0]          cand_arg;
  logic [CLS_W-1:0]          commit_cls;

  // Running max including the current score; ties keep the lower index.
  always_comb begin
    take       = (idx_q == '0) || (score_in > max_q);
    cand_max   = take ? score_in : max_q;
    cand_arg   = take ? idx_q : arg_q;
    commit_cls = cand_arg;
`ifdef DNN_DECIDE_SCORE_GATE_EN
    if (cand_max < MIN_S) commit_cls = CLS_W'(FILLER_CLASS);
`endif
  end

  // Accept a score, advance the index and close the frame on the last class.
  always_comb begin
    idx_d = idx_q;
    arg_d = arg_q;
    max_d = max_q;
    cls_d = cls_q;
    fv_d  = 1'b0;
`ifdef DNN_DECIDE_SCORE_GATE_EN
    best_d = best_q;
`endif
    if (score_dv) begin
      arg_d = cand_arg;
      max_d = cand_max;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        cls_d = commit_cls;
        fv_d  = 1'b1;
`ifdef DNN_DECIDE_SCORE_GATE_EN
        best_d = cand_max;
`endif
      end else begin
        idx_d = idx_q + CLS_W'(1);
      end
    end
  end

  // State registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      arg_q <= '0;
      max_q <= '0;
      cls_q <= '0;
      fv_q  <= 1'b0;
`ifdef DNN_DECIDE_SCORE_GATE_EN
      best_q <= '0;
`endif
    end else begin
      idx_q <= idx_d;
      arg_q <= arg_d;
      max_q <= max_d;
      cls_q <= cls_d;
      fv_q  <= fv_d;
`ifdef DNN_DECIDE_SCORE_GATE_EN
      best_q <= best_d;
`endif
    end
  end

  assign frame_class = cls_q;
  assign frame_valid = fv_q;
`ifdef DNN_DECIDE_SCORE_GATE_EN
  assign best_score  = best_q;
`endif

endmodule

// File: rtl/dnn_word_decider.sv
// Keyword decision stage: frame argmax, sliding-window vote, refractory hold.
// DNN_DECIDE_SCORE_GATE_EN enables the MIN_SCORE gate and the best_score port.
module dnn_word_decider
  import dnn_pkg::*;
#(
  parameter int unsigned NUM_CLASS = DEF_NUM_CLASS,
  parameter int unsigned SCORE_W   = DEF_SCORE_W,
  parameter int unsigned WIN       = 16,
  parameter int unsigned THRESH    = 10,
  parameter int unsigned HOLD      = 20,
`ifdef DNN_DECIDE_SCORE_GATE_EN
  parameter int          MIN_SCORE = 0,
`endif
  localparam int unsigned CLS_W    = cls_w(NUM_CLASS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [SCORE_W-1:0] score_in,
  input  logic                      score_dv,
  output logic [CLS_W-1:0]          frame_class,
  output logic                      frame_valid,
  output logic [CLS_W-1:0]          word_id,
  output logic                      word_valid,
`ifdef DNN_DECIDE_SCORE_GATE_EN
  output logic signed [SCORE_W-1:0] best_score,
`endif
  output logic                      hold_busy
);

  localparam int unsigned CNT_W  = $clog2(WIN + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);

  logic [CLS_W-1:0]  hist_q [WIN];
  logic [CLS_W-1:0]  hist_d [WIN];
  logic [CNT_W-1:0]  cnt_q  [NUM_CLASS];
  logic [CNT_W-1:0]  cnt_d  [NUM_CLASS];
  logic [CNT_W-1:0]  cnt_upd[NUM_CLASS];
  decide_state_e     state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CLS_W-1:0]  word_id_q, word_id_d;
  logic              word_valid_q, word_valid_d;
  logic              hold_busy_q, hold_busy_d;
  logic [CLS_W-1:0]  new_cls, old_cls;

  dnn_frame_argmax #(
    .NUM_CLASS (NUM_CLASS),
`ifdef DNN_DECIDE_SCORE_GATE_EN
    .MIN_SCORE (MIN_SCORE),
`endif
    .SCORE_W   (SCORE_W)
  ) u_argmax (
    .clk         (clk),
    .reset       (reset),
    .score_in    (score_in),
    .score_dv    (score_dv),
`ifdef DNN_DECIDE_SCORE_GATE_EN
    .best_score  (best_score),
`endif
    .frame_class (frame_class),
    .frame_valid (frame_valid)
  );

  // Window counters after pushing the committed class and evicting the oldest.
  always_comb begin
    new_cls = frame_class;
    old_cls = hist_q[WIN-1];
    for (int unsigned c = 0; c < NUM_CLASS; c++) begin
      cnt_upd[c] = cnt_q[c];
      if (new_cls != old_cls) begin
        if (new_cls == CLS_W'(c))      cnt_upd[c] = cnt_q[c] + CNT_W'(1);
        else if (old_cls == CLS_W'(c)) cnt_upd[c] = cnt_q[c] - CNT_W'(1);
      end
    end
  end

  // History shift and detect/hold FSM, both advancing once per committed frame.
  always_comb begin
    hist_d       = hist_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    hold_d       = hold_q;
    word_id_d    = word_id_q;
    word_valid_d = 1'b0;
    hold_busy_d  = hold_busy_q;

    if (frame_valid) begin
      for (int unsigned i = WIN - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = new_cls;
      cnt_d     = cnt_upd;
    end

    case (state_q)
      IDLE: begin
        if (frame_valid && (new_cls != CLS_W'(FILLER_CLASS)) &&
            (cnt_upd[new_cls] >= CNT_W'(THRESH))) begin
          word_valid_d = 1'b1;
          word_id_d    = new_cls;
          hold_d       = HOLD_W'(HOLD);
          hold_busy_d  = 1'b1;
          state_d      = DETECT;
        end
      end
      DETECT: state_d = HOLD_ST;
      HOLD_ST: begin
        if (frame_valid) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d      = '0;
            hold_busy_d = 1'b0;
            state_d     = IDLE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decision registers; history resets to a window full of filler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WIN; i++) hist_q[i] <= CLS_W'(FILLER_CLASS);
      for (int unsigned c = 0; c < NUM_CLASS; c++)
        cnt_q[c] <= (c == FILLER_CLASS) ? CNT_W'(WIN) : '0;
      state_q      <= IDLE;
      hold_q       <= '0;
      word_id_q    <= '0;
      word_valid_q <= 1'b0;
      hold_busy_q  <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      word_id_q    <= word_id_d;
      word_valid_q <= word_valid_d;
      hold_busy_q  <= hold_busy_d;
    end
  end

  assign word_id    = word_id_q;
  assign word_valid = word_valid_q;
  assign hold_busy  = hold_busy_q;

endmodule

// File: tb/tb_dnn_word_decider.sv
// Scoreboard bench for dnn_word_decider: a reference model predicts each frame
// winner and the vote/hold decision; the monitor pops and compares.
module tb_dnn_word_decider;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [10:0] score_in;
  logic               score_dv;
  logic [2:0]         frame_class;
  logic               frame_valid;
  logic [2:0]         word_id;
  logic               word_valid;
  logic               hold_busy;
`ifdef DNN_DECIDE_SCORE_GATE_EN
  logic signed [10:0] best_score;
`endif

  dnn_word_decider dut (
    .clk         (clk),
    .reset       (rst_n),
    .score_in    (score_in),
    .score_dv    (score_dv),
    .frame_class (frame_class),
    .frame_valid (frame_valid),
    .word_id     (word_id),
    .word_valid  (word_valid),
`ifdef DNN_DECIDE_SCORE_GATE_EN
    .best_score  (best_score),
`endif
    .hold_busy   (hold_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    bit word;
    int wid;
    bit busy;
    int cyc;
    int best;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  bit   chk_word = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fr[8];

  int   m_hist[16];
  int   m_cnt[8];
  int   m_hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_hist[i] = 0;
    for (int c = 0; c < 8; c++) m_cnt[c] = 0;
    m_cnt[0] = 16;
    m_hold   = 0;
  endtask

  // Predict the outcome of the frame held in fr[] and queue it.
  task automatic push_frame(input int exp_cyc);
    exp_t e;
    int   mx, am, old;
    mx = fr[0];
    am = 0;
    for (int i = 1; i < 8; i++) if (fr[i] > mx) begin mx = fr[i]; am = i; end
`ifdef DNN_DECIDE_SCORE_GATE_EN
    if (mx < 0) am = 0;
`endif
    old = m_hist[15];
    for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = am;
    m_cnt[am]++;
    m_cnt[old]--;
    e.word = 1'b0;
    e.wid  = 0;
    if (m_hold > 0) m_hold--;
    else if (am != 0 && m_cnt[am] >= 10) begin
      e.word = 1'b1;
      e.wid  = am;
      m_hold = 20;
    end
    e.cls  = am;
    e.busy = (m_hold > 0);
    e.cyc  = exp_cyc;
    e.best = mx;
    exp_q.push_back(e);
  endtask

  // Drive fr[] as one frame, entered and left on a falling edge.
  task automatic send_frame(input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_frame(cyc + 1);
      score_in = 11'(fr[i]);
      score_dv = 1'b1;
      @(negedge clk);
      score_dv = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (exp_q.size() != 0 || chk_word); k++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_class"}, frame_class, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_word_id"}, word_id, 0);
    check({tag, "_word_valid"}, word_valid, 0);
    check({tag, "_hold_busy"}, hold_busy, 0);
`ifdef DNN_DECIDE_SCORE_GATE_EN
    check({tag, "_best_score"}, best_score, 0);
`endif
  endtask

  // Monitor: frame result on frame_valid, decision one cycle later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_word) begin
        chk_word = 1'b0;
        check("word_valid", word_valid, pend.word);
        if (pend.word) check("word_id", word_id, pend.wid);
        check("hold_busy", hold_busy, pend.busy);
      end else if (word_valid) begin
        check("stray_word_valid", word_valid, 0);
      end
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", frame_valid, 0);
        end else begin
          pend = exp_q.pop_front();
          check("frame_class", frame_class, pend.cls);
          check("frame_latency_cycle", cyc, pend.cyc);
`ifdef DNN_DECIDE_SCORE_GATE_EN
          check("best_score", best_score, pend.best);
`endif
          chk_word = 1'b1;
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    score_dv = 1'b0;
    score_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Plain frame, then a tie resolved to the lower index.
    fr = '{5, -3, 12, 40, 7, 0, -1, 2};
    send_frame(0);
    fr = '{0, 9, 1, 1, 1, 9, 1, 1};
    send_frame(0);

    // Extremes: all equal minimum, and maximum at the last class.
    fr = '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024};
    send_frame(1);
    fr = '{-1024, 0, 5, 100, 200, 300, 1022, 1023};
    send_frame(0);
    drain();
    m_hist[0] = m_hist[0]; // keep model as-is; history continues

    // Ten class-2 frames with idle gaps trigger detection on the tenth.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = $urandom_range(0, 1523) - 1024;
      fr[2] = 500;
      send_frame(3);
    end
    // 25 more class-2 frames back-to-back: 20 held, then re-detection.
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = $urandom_range(0, 1023) - 1024;
      fr[2] = 1023;
      send_frame(0);
    end

    // Random frames, including negative-only maxima.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = $urandom_range(0, 2047) - 1024;
      send_frame(f % 2);
    end

    // All-negative frame: raw winner is class 4, gated build reports filler.
    fr = '{-10, -9, -8, -7, -2, -5, -6, -3};
    send_frame(0);
    drain();

    // Reset after four scores discards the partial frame.
    for (int i = 0; i < 4; i++) begin
      score_in = 11'sd900;
      score_dv = 1'b1;
      @(negedge clk);
    end
    score_dv = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr = '{1, 2, 3, 4, 5, 6, 50, 7};
    send_frame(0);
    fr = '{0, 0, 0, 0, 0, 77, 0, 0};
    send_frame(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends with a summary.
  initial begin
    #200000;
    check("watchdog_timeout", cyc, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
